if_fetch_ctrl: RTL and testbench

Instruction-fetch controller for the pipelined CPU.
- Reads the current address from the pc register and issues it to instruction memory over a req/gnt + rvalid handshake.
- Writes the next address back into pc through its load-enable/address inputs.
- Fills the IF/ID pipeline register, honouring ID-stage stalls and EX-stage branch/jump redirects.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 72 +++++++
 rtl/if_fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU: datapath widths, reset/bubble
// constants and the instruction-fetch state encoding.
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  // BOOT loads RESET_PC into pc, FETCH requests, WAIT awaits the response,
  // HOLD parks a response that ID could not take yet.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush, stall and load. Flush beats stall,
// stall beats load, and an unstalled cycle without a load becomes a bubble.
// The pc fields are left untouched by bubbles and flushes.
module if_id_reg #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INST_W   = cpu_pkg::INST_W,
  parameter logic [INST_W-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              stall,
  input  logic              load,
  input  logic [INST_W-1:0] load_inst,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [ADDR_W-1:0] load_pc4,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4
);

  logic              valid_d, valid_q;
  logic [INST_W-1:0] inst_d,  inst_q;
  logic [ADDR_W-1:0] pc_d,    pc_q;
  logic [ADDR_W-1:0] pc4_d,   pc4_q;

  // Next-state selection: flush > stall (hold) > load > bubble.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else if (!stall) begin
      if (load) begin
        valid_d = 1'b1;
        inst_d  = load_inst;
        pc_d    = load_pc;
        pc4_d   = load_pc4;
      end else begin
        valid_d = 1'b0;
        inst_d  = NOP_INST;
      end
    end
  end

  // Register update with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr) begin
    // NOTE: state is written with <= so every flop samples pre-edge values, independent of block order.
    if (!clr) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      pc_q    <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign inst  = inst_q;
  assign pc    = pc_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: sequences the pc register, issues one fetch
// at a time over req/gnt + rvalid, and fills the IF/ID register while
// honouring ID stalls and EX redirects.
module if_fetch_ctrl #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INST_W   = cpu_pkg::INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [INST_W-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic              pc_en,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_stall,
  output logic              if_id_valid,
  output logic [INST_W-1:0] if_id_inst,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc4
);

  import cpu_pkg::*;

  fetch_state_e      state_d, state_q;
  logic              drop_d, drop_q;          // pending response must be discarded
  logic [ADDR_W-1:0] req_pc_d, req_pc_q;      // address of the outstanding fetch
  logic [INST_W-1:0] hold_inst_d, hold_inst_q;
  logic [ADDR_W-1:0] hold_pc_d, hold_pc_q;    // hold buffer is live exactly in HOLD

  logic              ld;
  logic [INST_W-1:0] ld_inst;
  logic [ADDR_W-1:0] ld_pc;
  logic [ADDR_W-1:0] ld_pc4;

  assign imem_addr = pc_cur;
  assign ld_pc4    = ld_pc + ADDR_W'(4);

  // FSM, next-pc mux and IF/ID load selection.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    req_pc_d    = req_pc_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    imem_req    = 1'b0;
    pc_en       = 1'b0;
    pc_next     = RESET_PC;
    ld          = 1'b0;
    ld_inst     = imem_rdata;
    ld_pc       = req_pc_q;

    case (state_q)
      BOOT: begin
        pc_en   = 1'b1;
        pc_next = RESET_PC;
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          req_pc_d = pc_cur;
          pc_en    = 1'b1;
          pc_next  = pc_cur + ADDR_W'(4);
          drop_d   = redirect_valid;   // redirected while granted: response is stale
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = FETCH;
          drop_d  = 1'b0;
          if (!drop_q && !redirect_valid) begin
            if (!id_stall) begin
              ld = 1'b1;
            end else begin
              hold_inst_d = imem_rdata;
              hold_pc_d   = req_pc_q;
              state_d     = HOLD;
            end
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_d = FETCH;
        end else if (!id_stall) begin
          ld      = 1'b1;
          ld_inst = hold_inst_q;
          ld_pc   = hold_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase

    // A taken branch/jump wins over BOOT and the +4 load.
    if (redirect_valid) begin
      pc_en   = 1'b1;
      pc_next = redirect_pc;
    end

    // While clr is low the state flops already read BOOT, which would
    // otherwise assert pc_en; the outputs must show reset values at once.
    if (!clr) begin
      imem_req = 1'b0;
      pc_en    = 1'b0;
      pc_next  = RESET_PC;
    end
  end

  // Control and buffer registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= BOOT;
      drop_q      <= 1'b0;
      req_pc_q    <= '0;
      hold_inst_q <= NOP_INST;
      hold_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      req_pc_q    <= req_pc_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

  if_id_reg #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk       (clk),
    .clr       (clr),
    .flush     (redirect_valid),
    .stall     (id_stall),
    .load      (ld),
    .load_inst (ld_inst),
    .load_pc   (ld_pc),
    .load_pc4  (ld_pc4),
    .valid     (if_id_valid),
    .inst      (if_id_inst),
    .pc        (if_id_pc),
    .pc4       (if_id_pc4)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a pc register and a memory with variable response
// latency around the DUT, checked every cycle against a transaction-level
// reference model (outstanding fetch, held response, expected IF/ID).
module tb_if_fetch_ctrl;

  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] pc_cur;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk            (clk),
    .clr            (clr),
    .pc_cur         (pc_cur),
    .pc_en          (pc_en),
    .pc_next        (pc_next),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_id_valid    (if_id_valid),
    .if_id_inst     (if_id_inst),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Memory: one accepted request, answered after 1 + lat cycles.
  bit          mem_busy;
  int unsigned mem_cnt;
  int unsigned mem_lat_min;
  int unsigned mem_lat_max;
  logic [31:0] mem_addr;

  // Reference model.
  bit          m_boot;        // next cycle reloads RESET_PC
  bit          m_out;         // a fetch is outstanding
  bit          m_drop;        // its response is stale
  logic [31:0] m_out_pc;
  bit          m_held;        // a response is parked waiting for ID
  logic [31:0] m_held_inst;
  logic [31:0] m_held_pc;
  bit          e_valid;
  logic [31:0] e_inst;
  logic [31:0] e_pc;
  logic [31:0] e_pc4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_boot   = 1'b1;
    m_out    = 1'b0;
    m_drop   = 1'b0;
    m_held   = 1'b0;
    e_valid  = 1'b0;
    e_inst   = NOP;
    e_pc     = '0;
    e_pc4    = '0;
    mem_busy = 1'b0;
    mem_cnt  = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   32'(imem_req),    32'd0);
    check({tag, "_pc_en"}, 32'(pc_en),       32'd0);
    check({tag, "_pcnxt"}, pc_next,          RESET_PC);
    check({tag, "_valid"}, 32'(if_id_valid), 32'd0);
    check({tag, "_inst"},  if_id_inst,       NOP);
    check({tag, "_pc"},    if_id_pc,         32'd0);
    check({tag, "_pc4"},   if_id_pc4,        32'd0);
  endtask

  // One clock cycle: drive at negedge, compare mid-cycle, advance after posedge.
  task automatic cycle(input bit gnt_i, input bit redir_i, input logic [31:0] rpc_i,
                       input bit stall_i, input bit spur_i);
    bit          real_rv, exp_req, exp_en, acc, dlv;
    logic [31:0] exp_next, acc_addr, dlv_inst, dlv_pc;
    @(negedge clk);
    real_rv        = mem_busy && (mem_cnt == 0);
    imem_gnt       = gnt_i;
    redirect_valid = redir_i;
    redirect_pc    = rpc_i;
    id_stall       = stall_i;
    imem_rvalid    = real_rv || (!mem_busy && spur_i);
    imem_rdata     = real_rv ? (mem_addr ^ KEY) : $urandom;
    #1;
    exp_req  = !m_boot && !m_out && !m_held;
    exp_en   = redir_i || m_boot || (exp_req && gnt_i);
    exp_next = redir_i ? rpc_i : (m_boot ? RESET_PC : pc_cur + 32'd4);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, pc_cur);
    check("pc_en", 32'(pc_en), 32'(exp_en));
    if (exp_en) check("pc_next", pc_next, exp_next);
    check("if_id_valid", 32'(if_id_valid), 32'(e_valid));
    check("if_id_inst", if_id_inst, e_inst);
    if (e_valid) begin
      check("if_id_pc", if_id_pc, e_pc);
      check("if_id_pc4", if_id_pc4, e_pc4);
    end
    acc      = imem_req && gnt_i;
    acc_addr = imem_addr;
    @(posedge clk);
    #1;
    // memory side
    if (real_rv) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt > 0) mem_cnt = mem_cnt - 1;
    if (acc) begin
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(mem_lat_max, mem_lat_min);
      mem_addr = acc_addr;
    end
    // reference model
    dlv      = 1'b0;
    dlv_inst = NOP;
    dlv_pc   = '0;
    if (m_held) begin
      if (redir_i) m_held = 1'b0;
      else if (!stall_i) begin
        dlv = 1'b1; dlv_inst = m_held_inst; dlv_pc = m_held_pc; m_held = 1'b0;
      end
    end else if (m_out) begin
      if (imem_rvalid) begin
        if (!redir_i && !m_drop) begin
          if (!stall_i) begin
            dlv = 1'b1; dlv_inst = imem_rdata; dlv_pc = m_out_pc;
          end else begin
            m_held = 1'b1; m_held_inst = imem_rdata; m_held_pc = m_out_pc;
          end
        end
        m_out  = 1'b0;
        m_drop = 1'b0;
      end else if (redir_i) begin
        m_drop = 1'b1;
      end
    end
    if (exp_req && gnt_i) begin
      m_out    = 1'b1;
      m_out_pc = pc_cur;
      m_drop   = redir_i;
    end
    m_boot = 1'b0;
    if (redir_i) begin
      e_valid = 1'b0;
      e_inst  = NOP;
    end else if (!stall_i) begin
      if (dlv) begin
        e_valid = 1'b1; e_inst = dlv_inst; e_pc = dlv_pc; e_pc4 = dlv_pc + 32'd4;
      end else begin
        e_valid = 1'b0; e_inst = NOP;
      end
    end
    if (exp_en) pc_cur = exp_next;
  endtask

  initial begin
    clr            = 1'b0;
    pc_cur         = 32'hDEAD_BEE0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_stall       = 1'b0;
    mem_lat_min    = 0;
    mem_lat_max    = 0;
    mem_addr       = '0;
    model_reset();

    // reset values, then release just after a rising edge
    #2;
    check_reset("por");
    @(posedge clk);
    #1 clr = 1'b1;

    // streaming with 1-cycle gnt and rvalid: 0,4,8,C...
    for (int i = 0; i < 9; i++) cycle(1, 0, '0, 0, 0);

    // ID stall across a response: HOLD, no request, release
    for (int i = 0; i < 3; i++) cycle(1, 0, '0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, '0, 0, 0);

    // redirect during WAIT (response still one cycle away)
    mem_lat_min = 1;
    mem_lat_max = 1;
    for (int i = 0; i < 6 && !m_out; i++) cycle(1, 0, '0, 0, 0);
    check("reach_wait", 32'(imem_req), 32'd0);
    cycle(0, 1, 32'h0000_0100, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, '0, 0, 0);

    // redirect coincident with gnt in FETCH
    mem_lat_min = 0;
    mem_lat_max = 0;
    for (int i = 0; i < 6 && (m_out || m_held); i++) cycle(1, 0, '0, 0, 0);
    check("reach_fetch", 32'(imem_req), 32'd1);
    cycle(1, 1, 32'h0000_0200, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, '0, 0, 0);

    // wrap of the +4 arithmetic at the top of the address space
    for (int i = 0; i < 6 && (m_out || m_held); i++) cycle(1, 0, '0, 0, 0);
    cycle(0, 1, 32'hFFFF_FFFC, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, '0, 0, 0);

    // clr pulsed low while a fetch is outstanding
    mem_lat_min = 2;
    mem_lat_max = 2;
    for (int i = 0; i < 6 && !m_out; i++) cycle(1, 0, '0, 0, 0);
    check("reach_wait2", 32'(imem_req), 32'd0);
    @(negedge clk);
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    id_stall       = 1'b0;
    #2 clr = 1'b0;
    #1;
    check_reset("mid_wait");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b1;
    mem_lat_min = 0;
    mem_lat_max = 0;
    for (int i = 0; i < 8; i++) cycle(1, 0, '0, 0, 0);

    // randomized traffic
    mem_lat_min = 0;
    mem_lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      case ($urandom_range(3, 0))
        0:       rpc = 32'hFFFF_FFFC;
        1:       rpc = $urandom;
        default: rpc = $urandom & 32'hFFFF_FFFC;
      endcase
      cycle($urandom_range(3, 0) != 0, $urandom_range(11, 0) == 0, rpc,
            $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
